// File: rtl/mixer.sv
// Signed fixed-point up-mixer: mix_o = round(interp_i * LO) rescaled; MIXER_SAT_EN selects saturate vs wrap.
// Latency 2 cycles (input register, product register); one result per clock.
// No backpressure: free-running pipeline, a new pair is accepted every cycle.
module mixer #(
  parameter int WIDTH     = 20,
  parameter int FRAC_BITS = 14
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] interp_i,
  input  logic signed [WIDTH-1:0] LO,
  output logic signed [WIDTH-1:0] mix_o
);

  localparam int PW = 2 * WIDTH;
  localparam int RW = 2 * WIDTH - FRAC_BITS;
  localparam logic signed [PW:0] HALF =
    {{(PW + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};

  logic signed [WIDTH-1:0] a_q;
  logic signed [WIDTH-1:0] b_q;
  logic signed [PW-1:0]    prod;
  logic signed [PW:0]      sum;
  logic signed [RW-1:0]    r;
  logic signed [WIDTH-1:0] red;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= interp_i;
      b_q <= LO;
    end
  end

  // Extra adder bit keeps the rounding increment from wrapping the full-width product.
  always_comb begin
    prod = a_q * b_q;
    sum  = {prod[PW-1], prod} + HALF;
    r    = RW'(sum >>> FRAC_BITS);
  end

`ifdef MIXER_SAT_EN
  logic ovf_hi;
  logic ovf_lo;

  // r fits in WIDTH bits only when its bits above the WIDTH-1 sign bit all match the sign.
  always_comb begin
    ovf_hi = !r[RW-1] && (r[RW-1:WIDTH-1] != '0);
    ovf_lo =  r[RW-1] && (r[RW-1:WIDTH-1] != '1);
    if (ovf_hi)
      red = {1'b0, {(WIDTH - 1){1'b1}}};
    else if (ovf_lo)
      red = {1'b1, {(WIDTH - 1){1'b0}}};
    else
      red = r[WIDTH-1:0];
  end
`else
  always_comb begin
    red = WIDTH'(r);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      mix_o <= '0;
    else
      mix_o <= red;
  end

endmodule

// File: tb/tb_mixer.sv
// Directed bench for mixer: table of hand-computed products applied singly and streamed,
// plus reset hold, asynchronous reset assertion and mid-stream reset recovery.
module tb_mixer;

  localparam int WIDTH = 20;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  logic                    clock;
  logic                    reset_n;
  logic signed [WIDTH-1:0] interp_i;
  logic signed [WIDTH-1:0] LO;
  logic signed [WIDTH-1:0] mix_o;

  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  mixer #(.WIDTH(WIDTH), .FRAC_BITS(14)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .interp_i (interp_i),
    .LO       (LO),
    .mix_o    (mix_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: mix_o=0x%05h expected 0x%05h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] exp);
    vec_t v;
    v.name = name;
    v.a    = a;
    v.b    = b;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    interp_i = '0;
    LO       = '0;

    add("unity",      20'h04000, 20'h04000, 20'h04000);
    add("round_30000",20'h00064, 20'h0012C, 20'h00002);
    add("half_up",    20'h00001, 20'h02000, 20'h00001);
    add("neg_half",   20'hFFFFF, 20'h02000, 20'h00000);
    add("pos_1p5",    20'h00003, 20'h02000, 20'h00002);
    add("neg_1p5",    20'hFFFFD, 20'h02000, 20'hFFFFF);
    add("neg_one",    20'hFC000, 20'h04000, 20'hFC000);
    add("neg_neg",    20'hFC000, 20'hFC000, 20'h04000);
    add("two_x_mhalf",20'h08000, 20'hFE000, 20'hFC000);
    add("zero_a",     20'h00000, 20'h7FFFF, 20'h00000);
    add("zero_b",     20'h80000, 20'h00000, 20'h00000);
`ifdef MIXER_SAT_EN
    add("min_min",    20'h80000, 20'h80000, 20'h7FFFF);
    add("min_max",    20'h80000, 20'h7FFFF, 20'h80000);
    add("max_max",    20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
    add("eight_sq",   20'h20000, 20'h20000, 20'h7FFFF);
`else
    add("min_min",    20'h80000, 20'h80000, 20'h00000);
    add("min_max",    20'h80000, 20'h7FFFF, 20'h00020);
    add("max_max",    20'h7FFFF, 20'h7FFFF, 20'hFFFC0);
    add("eight_sq",   20'h20000, 20'h20000, 20'h00000);
`endif

    // Reset held with random inputs: output stays 0 on every edge.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      interp_i = $urandom;
      LO       = $urandom;
      check("reset_hold", mix_o, '0);
    end
    @(negedge clock);
    interp_i = '0;
    LO       = '0;
    reset_n  = 1'b1;

    // Isolated pairs: result appears exactly two rising edges after the inputs.
    foreach (vecs[i]) begin
      @(negedge clock);
      interp_i = vecs[i].a;
      LO       = vecs[i].b;
      @(negedge clock);
      interp_i = '0;
      LO       = '0;
      @(negedge clock);
      check(vecs[i].name, mix_o, vecs[i].exp);
      @(negedge clock);
      check({vecs[i].name, "_flush"}, mix_o, '0);
    end

    // Streaming: new pair every cycle, each result two edges later, none dropped.
    for (int k = 0; k < vecs.size() + 2; k++) begin
      @(negedge clock);
      if (k >= 2)
        check({"stream_", vecs[k-2].name}, mix_o, vecs[k-2].exp);
      if (k < vecs.size()) begin
        interp_i = vecs[k].a;
        LO       = vecs[k].b;
      end else begin
        interp_i = '0;
        LO       = '0;
      end
    end

    // Mid-stream asynchronous reset between edges, then recovery.
    @(negedge clock);
    interp_i = 20'hFC000;
    LO       = 20'h04000;
    @(negedge clock);
    interp_i = 20'h04000;
    LO       = 20'hFC000;
    @(negedge clock);
    check("pre_reset", mix_o, 20'hFC000);
    interp_i = 20'h08000;
    LO       = 20'h04000;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", mix_o, '0);
    @(negedge clock);
    check("reset_low", mix_o, '0);
    reset_n  = 1'b1;
    interp_i = 20'h04000;
    LO       = 20'h04000;
    @(negedge clock);
    interp_i = '0;
    LO       = '0;
    check("post_reset_e1", mix_o, '0);
    @(negedge clock);
    check("post_reset_first", mix_o, 20'h04000);
    @(negedge clock);
    check("post_reset_next", mix_o, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
